// File: rtl/tlb_op_ctrl.sv
// Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between EX and the TLB ports.
// Build option TLB_OP_STAT_EN adds search-hit/miss and fill counters.
module tlb_op_ctrl #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [4:0]      req_inv_op,
   input  logic [9:0]      req_inv_asid,
   input  logic [18:0]     req_inv_vppn,
   input  logic            tlbr_mode,
   input  logic [31:0]     csr_tlbidx,
   input  logic [31:0]     csr_tlbehi,
   input  logic [31:0]     csr_tlbelo0,
   input  logic [31:0]     csr_tlbelo1,
   input  logic [9:0]      csr_asid,
   output logic            tlb_s1_own,
   output logic [18:0]     tlb_s1_vppn,
   output logic [9:0]      tlb_s1_asid,
   input  logic            tlb_s1_found,
   input  logic [IDXW-1:0] tlb_s1_index,
   output logic            tlb_inv_valid,
   output logic [4:0]      tlb_inv_op,
   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index,
   output logic            tlb_w_e,
   output logic [18:0]     tlb_w_vppn,
   output logic [5:0]      tlb_w_ps,
   output logic [9:0]      tlb_w_asid,
   output logic            tlb_w_g,
   output logic [19:0]     tlb_w_ppn0,
   output logic [1:0]      tlb_w_plv0,
   output logic [1:0]      tlb_w_mat0,
   output logic            tlb_w_d0,
   output logic            tlb_w_v0,
   output logic [19:0]     tlb_w_ppn1,
   output logic [1:0]      tlb_w_plv1,
   output logic [1:0]      tlb_w_mat1,
   output logic            tlb_w_d1,
   output logic            tlb_w_v1,
   output logic [IDXW-1:0] tlb_r_index,
   input  logic            tlb_r_e,
   input  logic [18:0]     tlb_r_vppn,
   input  logic [5:0]      tlb_r_ps,
   input  logic [9:0]      tlb_r_asid,
   input  logic            tlb_r_g,
   input  logic [19:0]     tlb_r_ppn0,
   input  logic [1:0]      tlb_r_plv0,
   input  logic [1:0]      tlb_r_mat0,
   input  logic            tlb_r_d0,
   input  logic            tlb_r_v0,
   input  logic [19:0]     tlb_r_ppn1,
   input  logic [1:0]      tlb_r_plv1,
   input  logic [1:0]      tlb_r_mat1,
   input  logic            tlb_r_d1,
   input  logic            tlb_r_v1,
   output logic            done,
   output logic            done_exc,
   output logic [4:0]      csr_we,
   output logic [31:0]     csr_tlbidx_wd,
   output logic [31:0]     csr_tlbehi_wd,
   output logic [31:0]     csr_tlbelo0_wd,
   output logic [31:0]     csr_tlbelo1_wd,
   output logic [9:0]      csr_asid_wd
`ifdef TLB_OP_STAT_EN
   ,
   output logic [31:0]     stat_srch_hit,
   output logic [31:0]     stat_srch_miss,
   output logic [31:0]     stat_fill
`endif
);

   localparam logic [2:0] OpSrch = 3'd0;
   localparam logic [2:0] OpRead = 3'd1;
   localparam logic [2:0] OpWr   = 3'd2;
   localparam logic [2:0] OpFill = 3'd3;
   localparam logic [2:0] OpInv  = 3'd4;

   typedef enum logic [2:0] {StIdle, StSrch, StRead, StWrite, StInv, StDone} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      inv_op_q, inv_op_d;
   logic [9:0]      inv_asid_q, inv_asid_d;
   logic [18:0]     inv_vppn_q, inv_vppn_d;
   logic [IDXW-1:0] rand_idx_q, rand_idx_d;
   logic            done_q, done_d;
   logic            done_exc_q, done_exc_d;
   logic [4:0]      csr_we_q, csr_we_d;
   logic [31:0]     csr_tlbidx_wd_q, csr_tlbidx_wd_d;
   logic [31:0]     csr_tlbehi_wd_q, csr_tlbehi_wd_d;
   logic [31:0]     csr_tlbelo0_wd_q, csr_tlbelo0_wd_d;
   logic [31:0]     csr_tlbelo1_wd_q, csr_tlbelo1_wd_d;
   logic [9:0]      csr_asid_wd_q, csr_asid_wd_d;

   // State decodes are qualified by rstn so every strobe is low while reset is held.
   logic st_srch, st_read, st_write, st_inv;
   assign st_srch  = rstn & (state_q == StSrch);
   assign st_read  = rstn & (state_q == StRead);
   assign st_write = rstn & (state_q == StWrite);
   assign st_inv   = rstn & (state_q == StInv);

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      inv_op_d         = inv_op_q;
      inv_asid_d       = inv_asid_q;
      inv_vppn_d       = inv_vppn_q;
      rand_idx_d       = rand_idx_q + IDXW'(1);
      done_d           = 1'b0;
      done_exc_d       = 1'b0;
      csr_we_d         = 5'b0;
      csr_tlbidx_wd_d  = '0;
      csr_tlbehi_wd_d  = '0;
      csr_tlbelo0_wd_d = '0;
      csr_tlbelo1_wd_d = '0;
      csr_asid_wd_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d       = req_op;
               inv_op_d   = req_inv_op;
               inv_asid_d = req_inv_asid;
               inv_vppn_d = req_inv_vppn;
               case (req_op)
                  OpSrch:       state_d = StSrch;
                  OpRead:       state_d = StRead;
                  OpWr, OpFill: state_d = StWrite;
                  OpInv:        state_d = StInv;
                  default: begin
                     state_d    = StDone;
                     done_d     = 1'b1;
                     done_exc_d = 1'b1;
                  end
               endcase
            end
         end
         StSrch: begin
            state_d         = StDone;
            done_d          = 1'b1;
            csr_we_d        = 5'b00001;
            csr_tlbidx_wd_d = csr_tlbidx;
            csr_tlbidx_wd_d[31] = ~tlb_s1_found;
            if (tlb_s1_found) csr_tlbidx_wd_d[IDXW-1:0] = tlb_s1_index;
         end
         StRead: begin
            state_d         = StDone;
            done_d          = 1'b1;
            csr_we_d        = 5'b11111;
            csr_tlbidx_wd_d = csr_tlbidx;
            csr_tlbidx_wd_d[31]    = ~tlb_r_e;
            csr_tlbidx_wd_d[29:24] = tlb_r_e ? tlb_r_ps : 6'd0;
            if (tlb_r_e) begin
               csr_tlbehi_wd_d  = {tlb_r_vppn, 13'd0};
               csr_tlbelo0_wd_d = {4'd0, tlb_r_ppn0, 1'b0, tlb_r_g, tlb_r_mat0, tlb_r_plv0,
                                   tlb_r_d0, tlb_r_v0};
               csr_tlbelo1_wd_d = {4'd0, tlb_r_ppn1, 1'b0, tlb_r_g, tlb_r_mat1, tlb_r_plv1,
                                   tlb_r_d1, tlb_r_v1};
               csr_asid_wd_d    = tlb_r_asid;
            end
         end
         StWrite: begin
            state_d = StDone;
            done_d  = 1'b1;
         end
         StInv: begin
            state_d    = StDone;
            done_d     = 1'b1;
            done_exc_d = (inv_op_q > 5'd6);
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q          <= StIdle;
         op_q             <= '0;
         inv_op_q         <= '0;
         inv_asid_q       <= '0;
         inv_vppn_q       <= '0;
         rand_idx_q       <= '0;
         done_q           <= 1'b0;
         done_exc_q       <= 1'b0;
         csr_we_q         <= '0;
         csr_tlbidx_wd_q  <= '0;
         csr_tlbehi_wd_q  <= '0;
         csr_tlbelo0_wd_q <= '0;
         csr_tlbelo1_wd_q <= '0;
         csr_asid_wd_q    <= '0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         inv_op_q         <= inv_op_d;
         inv_asid_q       <= inv_asid_d;
         inv_vppn_q       <= inv_vppn_d;
         rand_idx_q       <= rand_idx_d;
         done_q           <= done_d;
         done_exc_q       <= done_exc_d;
         csr_we_q         <= csr_we_d;
         csr_tlbidx_wd_q  <= csr_tlbidx_wd_d;
         csr_tlbehi_wd_q  <= csr_tlbehi_wd_d;
         csr_tlbelo0_wd_q <= csr_tlbelo0_wd_d;
         csr_tlbelo1_wd_q <= csr_tlbelo1_wd_d;
         csr_asid_wd_q    <= csr_asid_wd_d;
      end
   end

   assign req_ready   = rstn & (state_q == StIdle);
   assign tlb_s1_own  = st_srch | st_inv;
   assign tlb_s1_vppn = st_srch ? csr_tlbehi[31:13] : (st_inv ? inv_vppn_q : 19'd0);
   assign tlb_s1_asid = st_srch ? csr_asid : (st_inv ? inv_asid_q : 10'd0);

   assign tlb_inv_valid = st_inv & (inv_op_q <= 5'd6);
   assign tlb_inv_op    = st_inv ? inv_op_q : 5'd0;

   assign tlb_we      = st_write;
   assign tlb_w_index = st_write ? ((op_q == OpFill) ? rand_idx_q : csr_tlbidx[IDXW-1:0]) : '0;
   assign tlb_w_e     = st_write & (tlbr_mode | ~csr_tlbidx[31]);
   assign tlb_w_vppn  = st_write ? csr_tlbehi[31:13] : 19'd0;
   assign tlb_w_ps    = st_write ? csr_tlbidx[29:24] : 6'd0;
   assign tlb_w_asid  = st_write ? csr_asid : 10'd0;
   assign tlb_w_g     = st_write & csr_tlbelo0[6] & csr_tlbelo1[6];
   assign tlb_w_ppn0  = st_write ? csr_tlbelo0[27:8] : 20'd0;
   assign tlb_w_plv0  = st_write ? csr_tlbelo0[3:2] : 2'd0;
   assign tlb_w_mat0  = st_write ? csr_tlbelo0[5:4] : 2'd0;
   assign tlb_w_d0    = st_write & csr_tlbelo0[1];
   assign tlb_w_v0    = st_write & csr_tlbelo0[0];
   assign tlb_w_ppn1  = st_write ? csr_tlbelo1[27:8] : 20'd0;
   assign tlb_w_plv1  = st_write ? csr_tlbelo1[3:2] : 2'd0;
   assign tlb_w_mat1  = st_write ? csr_tlbelo1[5:4] : 2'd0;
   assign tlb_w_d1    = st_write & csr_tlbelo1[1];
   assign tlb_w_v1    = st_write & csr_tlbelo1[0];

   assign tlb_r_index = st_read ? csr_tlbidx[IDXW-1:0] : '0;

   assign done           = rstn & done_q;
   assign done_exc       = rstn & done_exc_q;
   assign csr_we         = rstn ? csr_we_q : 5'd0;
   assign csr_tlbidx_wd  = csr_tlbidx_wd_q;
   assign csr_tlbehi_wd  = csr_tlbehi_wd_q;
   assign csr_tlbelo0_wd = csr_tlbelo0_wd_q;
   assign csr_tlbelo1_wd = csr_tlbelo1_wd_q;
   assign csr_asid_wd    = csr_asid_wd_q;

   // Low VPPN bits, ELO reserved bits and bit 7 carry nothing the TLB needs.
   logic unused_csr_bits;
   assign unused_csr_bits = ^{csr_tlbehi[12:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                              csr_tlbelo1[31:28], csr_tlbelo1[7]};

`ifdef TLB_OP_STAT_EN
   logic [31:0] stat_srch_hit_q, stat_srch_hit_d;
   logic [31:0] stat_srch_miss_q, stat_srch_miss_d;
   logic [31:0] stat_fill_q, stat_fill_d;

   // Hit/miss is recovered from the NE bit already latched for writeback.
   always_comb begin
      stat_srch_hit_d  = stat_srch_hit_q;
      stat_srch_miss_d = stat_srch_miss_q;
      stat_fill_d      = stat_fill_q;
      if (state_q == StDone) begin
         if (op_q == OpSrch) begin
            if (csr_tlbidx_wd_q[31]) stat_srch_miss_d = stat_srch_miss_q + 32'd1;
            else                     stat_srch_hit_d  = stat_srch_hit_q + 32'd1;
         end
         if (op_q == OpFill) stat_fill_d = stat_fill_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stat_srch_hit_q  <= '0;
         stat_srch_miss_q <= '0;
         stat_fill_q      <= '0;
      end else begin
         stat_srch_hit_q  <= stat_srch_hit_d;
         stat_srch_miss_q <= stat_srch_miss_d;
         stat_fill_q      <= stat_fill_d;
      end
   end

   assign stat_srch_hit  = stat_srch_hit_q;
   assign stat_srch_miss = stat_srch_miss_q;
   assign stat_fill      = stat_fill_q;
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a TLB array model on the port side, plus a reference model of
// the expected CSR writeback / TLB strobes computed from the op rules.
module tb_tlb_op_ctrl;
   localparam int TLBNUM = 16;
   localparam int IDXW   = 4;

   typedef struct packed {
      logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
      logic [19:0] ppn0; logic [1:0] plv0; logic [1:0] mat0; logic d0; logic v0;
      logic [19:0] ppn1; logic [1:0] plv1; logic [1:0] mat1; logic d1; logic v1;
   } ent_t;

   logic clk = 1'b0;
   logic rstn;
   logic req_valid, req_ready, tlbr_mode;
   logic [2:0] req_op;
   logic [4:0] req_inv_op;
   logic [9:0] req_inv_asid, csr_asid;
   logic [18:0] req_inv_vppn;
   logic [31:0] csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1;
   logic tlb_s1_own, tlb_s1_found, tlb_inv_valid, tlb_we;
   logic [18:0] tlb_s1_vppn;
   logic [9:0] tlb_s1_asid;
   logic [IDXW-1:0] tlb_s1_index, tlb_w_index, tlb_r_index;
   logic [4:0] tlb_inv_op;
   logic tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
   logic [18:0] tlb_w_vppn;
   logic [5:0] tlb_w_ps;
   logic [9:0] tlb_w_asid;
   logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
   logic [1:0] tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
   ent_t r_ent;
   logic done, done_exc;
   logic [4:0] csr_we;
   logic [31:0] csr_tlbidx_wd, csr_tlbehi_wd, csr_tlbelo0_wd, csr_tlbelo1_wd;
   logic [9:0] csr_asid_wd;

   tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
      .tlbr_mode(tlbr_mode), .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
      .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid),
      .tlb_s1_own(tlb_s1_own), .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid),
      .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
      .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
      .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
      .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
      .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0), .tlb_w_ppn1(tlb_w_ppn1),
      .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1), .tlb_w_d1(tlb_w_d1),
      .tlb_w_v1(tlb_w_v1), .tlb_r_index(tlb_r_index), .tlb_r_e(r_ent.e),
      .tlb_r_vppn(r_ent.vppn), .tlb_r_ps(r_ent.ps), .tlb_r_asid(r_ent.asid), .tlb_r_g(r_ent.g),
      .tlb_r_ppn0(r_ent.ppn0), .tlb_r_plv0(r_ent.plv0), .tlb_r_mat0(r_ent.mat0),
      .tlb_r_d0(r_ent.d0), .tlb_r_v0(r_ent.v0), .tlb_r_ppn1(r_ent.ppn1),
      .tlb_r_plv1(r_ent.plv1), .tlb_r_mat1(r_ent.mat1), .tlb_r_d1(r_ent.d1),
      .tlb_r_v1(r_ent.v1), .done(done), .done_exc(done_exc), .csr_we(csr_we),
      .csr_tlbidx_wd(csr_tlbidx_wd), .csr_tlbehi_wd(csr_tlbehi_wd),
      .csr_tlbelo0_wd(csr_tlbelo0_wd), .csr_tlbelo1_wd(csr_tlbelo1_wd),
      .csr_asid_wd(csr_asid_wd)
   );

   always #5 clk = ~clk;

   // TLB array on the port side: written by the DUT's write strobe.
   ent_t env_mem [TLBNUM];
   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < TLBNUM; i++) env_mem[i] <= '0;
      end else if (tlb_we) begin
         env_mem[tlb_w_index] <= {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                                  tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0,
                                  tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1};
      end
   end
   assign r_ent = env_mem[tlb_r_index];
   always_comb begin
      tlb_s1_found = 1'b0;
      tlb_s1_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (env_mem[i].e && env_mem[i].vppn == tlb_s1_vppn &&
             (env_mem[i].g || env_mem[i].asid == tlb_s1_asid)) begin
            tlb_s1_found = 1'b1;
            tlb_s1_index = IDXW'(i);
         end
      end
   end

   // Cycles since reset release; the FILL index is this count modulo TLBNUM.
   int unsigned cyc;
   always @(posedge clk) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int tests = 0;
   int fails = 0;
   ent_t ref_mem [TLBNUM];

   int last_lat, last_nwe, last_ninv;
   logic last_exc;
   logic [IDXW-1:0] last_widx;
   ent_t last_ent;
   logic [31:0] last_idx_wd, last_ehi_wd, last_elo0_wd, last_elo1_wd;
   logic [9:0] last_asid_wd, last_s1_asid;
   logic [18:0] last_s1_vppn;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_search(input logic [18:0] v, input logic [9:0] a);
      for (int i = 0; i < TLBNUM; i++)
         if (ref_mem[i].e && ref_mem[i].vppn == v && (ref_mem[i].g || ref_mem[i].asid == a))
            return i;
      return -1;
   endfunction

   function automatic logic [31:0] elo_word(input logic [19:0] ppn, input logic g,
                                            input logic [1:0] mat, input logic [1:0] plv,
                                            input logic d, input logic v);
      return {4'd0, ppn, 1'b0, g, mat, plv, d, v};
   endfunction

   function automatic ent_t exp_write_ent();
      ent_t t;
      t.e = tlbr_mode | ~csr_tlbidx[31];
      t.vppn = csr_tlbehi[31:13];
      t.ps = csr_tlbidx[29:24];
      t.asid = csr_asid;
      t.g = csr_tlbelo0[6] & csr_tlbelo1[6];
      t.ppn0 = csr_tlbelo0[27:8]; t.plv0 = csr_tlbelo0[3:2]; t.mat0 = csr_tlbelo0[5:4];
      t.d0 = csr_tlbelo0[1]; t.v0 = csr_tlbelo0[0];
      t.ppn1 = csr_tlbelo1[27:8]; t.plv1 = csr_tlbelo1[3:2]; t.mat1 = csr_tlbelo1[5:4];
      t.d1 = csr_tlbelo1[1]; t.v1 = csr_tlbelo1[0];
      return t;
   endfunction

   // Issue one op at the current negedge, observe 4 cycles, compare with the model.
   task automatic exec(input logic [2:0] op);
      int exp_lat, exp_nwe, exp_ninv, exp_nown, hit;
      logic exp_exc;
      logic [4:0] exp_we_csr;
      logic [31:0] e_idx, e_ehi, e_elo0, e_elo1;
      logic [9:0] e_asid, e_s1_asid;
      logic [18:0] e_s1_vppn;
      logic [IDXW-1:0] exp_widx;
      ent_t m, exp_ent;
      int n_we, n_inv, n_own, n_done, lat;
      int unsigned fill_cyc;
      logic [4:0] got_csr_we, got_inv_op;
      logic got_exc;
      exp_lat = 2; exp_nwe = 0; exp_ninv = 0; exp_nown = 0; exp_exc = 1'b0;
      exp_we_csr = 5'd0; e_idx = '0; e_ehi = '0; e_elo0 = '0; e_elo1 = '0; e_asid = '0;
      e_s1_vppn = '0; e_s1_asid = '0; exp_widx = csr_tlbidx[IDXW-1:0];
      exp_ent = exp_write_ent();
      m = ref_mem[csr_tlbidx[IDXW-1:0]];
      case (op)
         3'd0: begin
            exp_nown = 1; exp_we_csr = 5'b00001;
            e_s1_vppn = csr_tlbehi[31:13]; e_s1_asid = csr_asid;
            hit = ref_search(csr_tlbehi[31:13], csr_asid);
            e_idx = csr_tlbidx;
            e_idx[31] = (hit < 0);
            if (hit >= 0) e_idx[IDXW-1:0] = IDXW'(hit);
         end
         3'd1: begin
            exp_we_csr = 5'b11111;
            e_idx = csr_tlbidx;
            e_idx[31] = ~m.e;
            e_idx[29:24] = m.e ? m.ps : 6'd0;
            if (m.e) begin
               e_ehi = {m.vppn, 13'd0};
               e_elo0 = elo_word(m.ppn0, m.g, m.mat0, m.plv0, m.d0, m.v0);
               e_elo1 = elo_word(m.ppn1, m.g, m.mat1, m.plv1, m.d1, m.v1);
               e_asid = m.asid;
            end
         end
         3'd2, 3'd3: exp_nwe = 1;
         3'd4: begin
            exp_nown = 1; exp_ninv = (req_inv_op <= 5'd6) ? 1 : 0;
            exp_exc = (req_inv_op > 5'd6);
            e_s1_vppn = req_inv_vppn; e_s1_asid = req_inv_asid;
         end
         default: begin
            exp_lat = 1; exp_exc = 1'b1;
         end
      endcase
      n_we = 0; n_inv = 0; n_own = 0; n_done = 0; lat = 0; fill_cyc = 0;
      got_csr_we = 'x; got_exc = 1'bx; got_inv_op = '0;
      chk("accept_ready", req_ready, 1);
      req_op = op;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 1) fill_cyc = cyc;
         if (tlb_we) begin
            n_we++;
            last_widx = tlb_w_index;
            last_ent = {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_ppn0,
                        tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0, tlb_w_ppn1, tlb_w_plv1,
                        tlb_w_mat1, tlb_w_d1, tlb_w_v1};
         end
         if (tlb_s1_own) begin
            n_own++;
            last_s1_vppn = tlb_s1_vppn;
            last_s1_asid = tlb_s1_asid;
         end
         if (tlb_inv_valid) begin
            n_inv++;
            got_inv_op = tlb_inv_op;
         end
         if (done) begin
            n_done++;
            if (lat == 0) lat = c;
            got_exc = done_exc; got_csr_we = csr_we;
            last_idx_wd = csr_tlbidx_wd; last_ehi_wd = csr_tlbehi_wd;
            last_elo0_wd = csr_tlbelo0_wd; last_elo1_wd = csr_tlbelo1_wd;
            last_asid_wd = csr_asid_wd;
         end
         @(negedge clk);
      end
      if (op == 3'd3) exp_widx = IDXW'(fill_cyc % TLBNUM);
      chk("latency", lat, exp_lat);
      chk("done_count", n_done, 1);
      chk("done_exc", got_exc, exp_exc);
      chk("csr_we", got_csr_we, exp_we_csr);
      chk("we_count", n_we, exp_nwe);
      chk("inv_count", n_inv, exp_ninv);
      chk("s1_own_count", n_own, exp_nown);
      if (exp_we_csr[0]) chk("tlbidx_wd", last_idx_wd, e_idx);
      if (exp_we_csr[1]) chk("tlbehi_wd", last_ehi_wd, e_ehi);
      if (exp_we_csr[2]) chk("elo0_wd", last_elo0_wd, e_elo0);
      if (exp_we_csr[3]) chk("elo1_wd", last_elo1_wd, e_elo1);
      if (exp_we_csr[4]) chk("asid_wd", last_asid_wd, e_asid);
      if (exp_nwe == 1 && n_we == 1) begin
         chk("w_index", last_widx, exp_widx);
         chk("w_entry", last_ent, exp_ent);
      end
      if (exp_nwe == 1) ref_mem[exp_widx] = exp_ent;
      if (exp_nown == 1 && n_own == 1) begin
         chk("s1_vppn", last_s1_vppn, e_s1_vppn);
         chk("s1_asid", last_s1_asid, e_s1_asid);
      end
      if (exp_ninv == 1 && n_inv == 1) chk("inv_op", got_inv_op, req_inv_op);
      last_lat = lat; last_nwe = n_we; last_ninv = n_inv; last_exc = got_exc;
   endtask

   initial begin
      int w1, acc, nd, nwe;
      rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_inv_op = '0; req_inv_asid = '0;
      req_inv_vppn = '0; tlbr_mode = 1'b0; csr_tlbidx = '0; csr_tlbehi = '0;
      csr_tlbelo0 = '0; csr_tlbelo1 = '0; csr_asid = '0;
      for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_we", tlb_we, 0);
      chk("rst_own", tlb_s1_own, 0);
      chk("rst_csr_we", csr_we, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_ready", req_ready, 1);

      // T1 TLBWR at index 3
      csr_tlbidx = 32'h0C00_0003; csr_tlbehi = {19'h12345, 13'd0}; csr_asid = 10'h2A;
      csr_tlbelo0 = 32'h00AB_CD1F; csr_tlbelo1 = 32'h0065_4357;
      exec(3'd2);
      chk("t1_widx", last_widx, 3);
      chk("t1_we", last_ent.e, 1);
      chk("t1_lat", last_lat, 2);
      // T2 search hit, then miss with index kept
      exec(3'd0);
      chk("t2_hit_idx", last_idx_wd[3:0], 3);
      chk("t2_hit_ne", last_idx_wd[31], 0);
      csr_tlbehi = {19'h54321, 13'd0}; csr_tlbidx = 32'h0C00_0009;
      exec(3'd0);
      chk("t2_miss_ne", last_idx_wd[31], 1);
      chk("t2_miss_idx", last_idx_wd[3:0], 9);
      // T3 read back entry 3, then an invalid entry
      csr_tlbidx = 32'h0000_0003;
      exec(3'd1);
      chk("t3_ehi", last_ehi_wd, {19'h12345, 13'd0});
      chk("t3_ps", last_idx_wd[29:24], 12);
      chk("t3_elo0", last_elo0_wd, 32'h00AB_CD1F);
      chk("t3_elo1", last_elo1_wd, 32'h0065_4317);
      chk("t3_asid", last_asid_wd, 10'h2A);
      csr_tlbidx = 32'h0000_0005;
      exec(3'd1);
      chk("t3_inv_ne", last_idx_wd[31], 1);
      chk("t3_inv_ehi", last_ehi_wd, 0);
      chk("t3_inv_elo0", last_elo0_wd, 0);
      // T4 two FILLs 7 cycles apart; second with NE=1 under refill mode
      csr_tlbidx = 32'h0C00_0000; tlbr_mode = 1'b0;
      exec(3'd3);
      w1 = int'(last_widx);
      repeat (2) @(negedge clk);
      csr_tlbidx = 32'h8C00_0000; tlbr_mode = 1'b1;
      exec(3'd3);
      chk("t4_delta", (int'(last_widx) - w1) & 15, 7);
      chk("t4_we", last_ent.e, 1);
      tlbr_mode = 1'b0;
      // T5 INVTLB valid, invalid op, reserved req_op
      req_inv_op = 5'd5; req_inv_asid = 10'h2A; req_inv_vppn = 19'h12345;
      exec(3'd4);
      chk("t5_pulse", last_ninv, 1);
      chk("t5_vppn", last_s1_vppn, 19'h12345);
      req_inv_op = 5'd9;
      exec(3'd4);
      chk("t5_bad_exc", last_exc, 1);
      chk("t5_bad_pulse", last_ninv, 0);
      exec(3'd6);
      chk("rsv_lat", last_lat, 1);
      chk("rsv_exc", last_exc, 1);

      // Randomized ops against the reference model
      for (int n = 0; n < 60; n++) begin
         csr_tlbidx = {($urandom_range(0, 3) == 0), 1'b0,
                       ($urandom_range(0, 1) == 0) ? 6'd12 : 6'd21,
                       20'($urandom), 4'($urandom_range(0, 15))};
         csr_tlbehi = {19'h12345 + 19'($urandom_range(0, 3)), 13'($urandom)};
         csr_asid = 10'h2A + 10'($urandom_range(0, 1));
         csr_tlbelo0 = $urandom; csr_tlbelo1 = $urandom;
         tlbr_mode = 1'($urandom_range(0, 1));
         req_inv_op = 5'($urandom_range(0, 9));
         req_inv_asid = 10'($urandom); req_inv_vppn = 19'($urandom);
         exec(3'($urandom_range(0, 7)));
      end

      // T6 reset during WRITE aborts the op
      csr_tlbidx = 32'h0000_0002; req_op = 3'd2; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("t6_we_in_reset", tlb_we, 0);
      chk("t6_ready_in_reset", req_ready, 0);
      nwe = 0; nd = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) rstn = 1'b1;
         @(negedge clk);
         if (tlb_we) nwe++;
         if (done) nd++;
      end
      for (int i = 0; i < TLBNUM; i++) ref_mem[i] = '0;
      chk("t6_no_we", nwe, 0);
      chk("t6_no_done", nd, 0);
      // Held request while busy is accepted once
      csr_tlbehi = {19'h12345, 13'd0};
      req_op = 3'd0; req_valid = 1'b1; acc = 0; nd = 0;
      for (int c = 0; c < 3; c++) begin
         if (req_ready) acc++;
         if (done) nd++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("t6_accepts", acc, 1);
      chk("t6_dones", nd, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
